// File: rtl/board_io_pkg.sv
// Shared types and default constants for the board input conditioner.
// Sequencer states plus synchronizer, reset-hold and debounce defaults.
package board_io_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    HOLD,
    RUN
  } seq_state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned RST_HOLD_DEF    = 16;
  localparam int unsigned DEBOUNCE_DEF    = 100000;

endpackage

// File: rtl/board_input_cond_if.sv
// Raw-in / conditioned-out bundle between the top and a debouncer.
// The master drives the raw sample, the slave returns the clean value.
interface board_input_cond_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] q;

  modport master (
    output raw,
    input  q
  );

  modport slave (
    input  raw,
    output q
  );

endinterface

// File: rtl/io_debounce.sv
// Synchronizer chain followed by a whole-bus debouncer.
// The output changes only after a run of identical samples.
module io_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  board_input_cond_if.slave  db
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] stable_q;
  logic [CW-1:0]    cnt_q;

  assign sample = sync_q[SYNC_STAGES-1];
  assign db.q   = stable_q;

  // A fresh value counts as the first sample of its own run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync_q[0] <= db.raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sample;
      if (sample == stable_q) begin
        cnt_q <= '0;
      end else if (sample != prev_q) begin
        cnt_q <= CW'(1);
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sample;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_input_cond.sv
// Board input conditioner: PLL-lock reset sequencer, button irq
// and switch debouncing for the SoC.
module board_input_cond
  import board_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned RST_HOLD_CYCLES = RST_HOLD_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned SW_WIDTH        = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                pll_locked_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                rst_o,
  output logic                ready_o,
  output logic                irq_btn_o,
  output logic [SW_WIDTH-1:0] sw_o
);

  localparam int unsigned HW = $clog2(RST_HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  seq_state_e           state_q;
  logic [HW-1:0]        hold_cnt_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                 lock_s;
  logic                 btn_q;
  logic                 btn_prev_q;

  board_input_cond_if #(.WIDTH(1))        btn_if ();
  board_input_cond_if #(.WIDTH(SW_WIDTH)) sw_if ();

  assign btn_if.raw = btn_i;
  assign sw_if.raw  = sw_i;
  assign btn_q      = btn_if.q[0];
  assign sw_o       = sw_if.q;
  assign lock_s     = lock_sync_q[SYNC_STAGES-1];

  io_debounce #(
    .WIDTH           (1),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .db    (btn_if.slave)
  );

  io_debounce #(
    .WIDTH           (SW_WIDTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .db    (sw_if.slave)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ASSERT;
      hold_cnt_q <= '0;
      rst_o      <= 1'b1;
      ready_o    <= 1'b0;
    end else begin
      unique case (state_q)
        ASSERT: begin
          if (lock_s) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state_q    <= ASSERT;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q + 1'b1 >= HOLD_LAST) begin
            state_q    <= RUN;
            hold_cnt_q <= '0;
            rst_o      <= 1'b0;
            ready_o    <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q <= ASSERT;
            rst_o   <= 1'b1;
            ready_o <= 1'b0;
          end
        end
        default: begin
          state_q    <= ASSERT;
          hold_cnt_q <= '0;
          rst_o      <= 1'b1;
          ready_o    <= 1'b0;
        end
      endcase
    end
  end

  // Presses that finish debouncing outside RUN are simply lost
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      btn_prev_q <= 1'b0;
      irq_btn_o  <= 1'b0;
    end else begin
      btn_prev_q <= btn_q;
      irq_btn_o  <= btn_q & ~btn_prev_q & (state_q == RUN);
    end
  end

endmodule

// File: tb/tb_board_input_cond.sv
// Scoreboard bench for board_input_cond against a run-length model.
// Directed scenarios first, then randomized lock/button/switch traffic.
module tb_board_input_cond;

  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int DEB  = 8;
  localparam int SW   = 16;

  typedef struct packed {
    logic          rst;
    logic          ready;
    logic          irq;
    logic [SW-1:0] sw;
  } exp_t;

  logic clk;
  logic arst_n;
  logic pll_locked;
  logic btn;
  logic rst_o;
  logic ready_o;
  logic irq_btn_o;

  board_input_cond_if #(.WIDTH(SW)) sw_bus ();

  board_input_cond #(
    .SYNC_STAGES     (SYNC),
    .RST_HOLD_CYCLES (HOLD),
    .DEBOUNCE_CYCLES (DEB),
    .SW_WIDTH        (SW)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .pll_locked_i (pll_locked),
    .btn_i        (btn),
    .sw_i         (sw_bus.raw),
    .rst_o        (rst_o),
    .ready_o      (ready_o),
    .irq_btn_o    (irq_btn_o),
    .sw_o         (sw_bus.q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int irq_cnt  = 0;
  int cyc      = 0;
  exp_t sb[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h, want %0h",
                  nm, cyc, act, exp);
  endtask

  // Reference model: sampled value is the input SYNC edges ago;
  // outputs follow run lengths of identical samples.
  logic          m_lock_d [SYNC];
  logic          m_btn_d  [SYNC];
  logic [SW-1:0] m_sw_d   [SYNC];
  int            lock_run, b_run, s_run;
  logic          b_last, b_stable, b_rose;
  logic [SW-1:0] s_last, s_stable;
  logic          m_ready, m_irq;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) begin
      m_lock_d[i] = 1'b0;
      m_btn_d[i]  = 1'b0;
      m_sw_d[i]   = '0;
    end
    lock_run = 0;
    b_run    = 0;
    s_run    = 0;
    b_last   = 1'b0;
    b_stable = 1'b0;
    b_rose   = 1'b0;
    s_last   = '0;
    s_stable = '0;
    m_ready  = 1'b0;
    m_irq    = 1'b0;
  endtask

  task automatic model_edge();
    logic          ls, bs;
    logic [SW-1:0] ss;
    ls = m_lock_d[SYNC-1];
    bs = m_btn_d[SYNC-1];
    ss = m_sw_d[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) begin
      m_lock_d[i] = m_lock_d[i-1];
      m_btn_d[i]  = m_btn_d[i-1];
      m_sw_d[i]   = m_sw_d[i-1];
    end
    m_lock_d[0] = pll_locked;
    m_btn_d[0]  = btn;
    m_sw_d[0]   = sw_bus.raw;

    m_irq = b_rose & m_ready;

    lock_run = ls ? ((lock_run < 1000) ? lock_run + 1 : lock_run) : 0;
    m_ready  = (lock_run >= HOLD);

    b_run  = (bs == b_last) ? ((b_run < 1000) ? b_run + 1 : b_run) : 1;
    b_last = bs;
    b_rose = 1'b0;
    if (b_run >= DEB && bs != b_stable) begin
      b_rose   = bs;
      b_stable = bs;
    end

    s_run  = (ss == s_last) ? ((s_run < 1000) ? s_run + 1 : s_run) : 1;
    s_last = ss;
    if (s_run >= DEB && ss != s_stable) s_stable = ss;
  endtask

  logic          nxt_a, nxt_l, nxt_b;
  logic [SW-1:0] nxt_s;

  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (arst_n) model_edge();
      else model_reset();
      arst_n     = nxt_a;
      pll_locked = nxt_l;
      btn        = nxt_b;
      sw_bus.raw = nxt_s;
      if (!nxt_a) model_reset();
      e.rst   = ~m_ready;
      e.ready = m_ready;
      e.irq   = m_irq;
      e.sw    = s_stable;
      sb.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (irq_btn_o) irq_cnt++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rst_o",     32'(rst_o),     32'(e.rst));
        check("ready_o",   32'(ready_o),   32'(e.ready));
        check("irq_btn_o", 32'(irq_btn_o), 32'(e.irq));
        check("sw_o",      32'(sw_bus.q),  32'(e.sw));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int k;
    int c0;
    int bhold;
    int shold;
    arst_n     = 1'b0;
    pll_locked = 1'b1;
    btn        = 1'b0;
    sw_bus.raw = '0;
    nxt_a = 1'b0;
    nxt_l = 1'b1;
    nxt_b = 1'b0;
    nxt_s = '0;
    model_reset();
    tick(3);
    #1;
    check("reset_rst", 32'(rst_o), 32'd1);
    check("reset_ready", 32'(ready_o), 32'd0);

    // Release with lock already high
    nxt_a = 1'b1;
    tick(1);
    k = 0;
    while (rst_o && k < 20) begin
      tick(1);
      k++;
    end
    check("rst_fall_cycle", 32'(k), 32'd6);
    check("ready_at_fall", 32'(ready_o), 32'd1);

    // One-cycle lock glitch in RUN
    nxt_l = 1'b0;
    tick(1);
    nxt_l = 1'b1;
    k = 0;
    while (!rst_o && k < 10) begin
      tick(1);
      k++;
    end
    check("lock_drop_rst_le3", 32'(k <= 3), 32'd1);
    tick(12);
    check("lock_back_ready", 32'(ready_o), 32'd1);

    // Bouncing button, then held
    c0 = irq_cnt;
    for (int i = 0; i < 40; i++) begin
      nxt_b = ((i / 3) % 2) != 0;
      tick(1);
    end
    k = 0;
    while (!irq_btn_o && k < 30) begin
      tick(1);
      k++;
    end
    check("btn_irq_latency", 32'(k), 32'd11);
    tick(5);
    check("btn_irq_count", 32'(irq_cnt - c0), 32'd1);
    nxt_b = 1'b0;
    tick(15);
    check("release_no_irq", 32'(irq_cnt - c0), 32'd1);

    // Switch change with a late bit-0 flip
    nxt_s = 16'hA5A5;
    tick(5);
    nxt_s = 16'hA5A4;
    tick(1);
    check("sw_still_zero", 32'(sw_bus.q), 32'h0);
    k = 0;
    while (sw_bus.q != 16'hA5A4 && k < 30) begin
      tick(1);
      k++;
    end
    check("sw_settle_cycles", 32'(k), 32'd10);

    // Press debounced while in reset, still held at RUN
    nxt_l = 1'b0;
    tick(4);
    nxt_b = 1'b1;
    tick(20);
    check("hold_rst_during_press", 32'(rst_o), 32'd1);
    c0 = irq_cnt;
    nxt_l = 1'b1;
    tick(15);
    check("run_after_press", 32'(ready_o), 32'd1);
    tick(1);
    check("dropped_press", 32'(irq_cnt - c0), 32'd0);
    nxt_b = 1'b0;
    tick(15);
    nxt_b = 1'b1;
    tick(15);
    check("second_press", 32'(irq_cnt - c0), 32'd1);

    // Async reset mid-debounce
    nxt_b = 1'b0;
    tick(15);
    nxt_b = 1'b1;
    tick(8);
    nxt_a = 1'b0;
    nxt_b = 1'b0;
    tick(1);
    #1;
    check("async_rst_o", 32'(rst_o), 32'd1);
    check("async_sw_o", 32'(sw_bus.q), 32'h0);
    tick(1);
    nxt_a = 1'b1;
    c0 = irq_cnt;
    tick(30);
    check("no_irq_after_rst", 32'(irq_cnt - c0), 32'd0);

    // Randomized traffic
    bhold = 0;
    shold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bhold == 0) begin
        nxt_b = 1'($urandom_range(0, 1));
        bhold = $urandom_range(1, 14);
      end else begin
        bhold--;
      end
      if (shold == 0) begin
        nxt_s = 16'($urandom);
        shold = $urandom_range(1, 14);
      end else begin
        shold--;
      end
      nxt_l = ($urandom_range(0, 149) != 0);
      nxt_a = ($urandom_range(0, 399) != 0);
      tick(1);
    end

    nxt_a = 1'b1;
    tick(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/board_input_cond.md
BOARD_INPUT_COND -- requirements
Module: board_input_cond

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flop depth for every asynchronous input (legal 2..4).
REQ-002 The module SHALL have parameter RST_HOLD_CYCLES, default 16, meaning cycles rst_o stays asserted after pll_locked_i is seen stable high.
REQ-003 The module SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning consecutive equal samples required before a debounced output changes (legal >=2).
REQ-004 The module SHALL have parameter SW_WIDTH, default 16, meaning switch bus width.
REQ-005 The module SHALL have port clk_i, input, 1 bit: the single clock (post-PLL system clock).
REQ-006 The module SHALL have port arst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port pll_locked_i, input, 1 bit: PLL lock, asynchronous to clk_i.
REQ-008 The module SHALL have port btn_i, input, 1 bit: raw push-button, active-high, bouncing.
REQ-009 The module SHALL have port sw_i, input, SW_WIDTH bits: raw slide switches.
REQ-010 The module SHALL have port rst_o, output, 1 bit: active-high SoC reset, deasserted synchronously to clk_i.
REQ-011 The module SHALL have port ready_o, output, 1 bit: high when the reset sequencer is in RUN.
REQ-012 The module SHALL have port irq_btn_o, output, 1 bit: single-cycle pulse on a debounced button press.
REQ-013 The module SHALL have port sw_o, output, SW_WIDTH bits: synchronized, debounced switch value.

Function
REQ-014 Every asynchronous input SHALL pass through a SYNC_STAGES flop chain before any other use.
REQ-015 The reset sequencer SHALL have states ASSERT, HOLD, RUN, with rst_o=1 in ASSERT and HOLD and rst_o=0 in RUN.
REQ-016 In ASSERT, the sequencer SHALL move to HOLD on the first cycle the synchronized lock is 1, with the hold counter cleared.
REQ-017 In HOLD, the hold counter SHALL increment each cycle the lock is 1, and the sequencer SHALL move to RUN when the count reaches RST_HOLD_CYCLES-1.
REQ-018 A synchronized lock of 0 in HOLD or RUN SHALL return the sequencer to ASSERT on the next edge, so that rst_o rises within SYNC_STAGES+1 cycles of pll_locked_i falling.
REQ-019 The button debouncer SHALL keep a stable state and a counter; the counter SHALL reset whenever the synchronized sample equals the stable state.
REQ-020 When the sample differs from the stable state, the debouncer counter SHALL increment, and on reaching DEBOUNCE_CYCLES-1 the stable state SHALL take the sample value and the counter SHALL clear.
REQ-021 irq_btn_o SHALL pulse for exactly one cycle, on the cycle after the debounced button state changes 0->1, and only while in RUN.
REQ-022 Presses that complete debounce outside RUN SHALL be dropped, not queued; releases SHALL never pulse.
REQ-023 The switch debouncer SHALL treat the bus as a whole: any bit change in the synchronized sample restarts the counter, and sw_o SHALL update to the full sample after DEBOUNCE_CYCLES unchanged cycles.
REQ-024 Every counter SHALL saturate or clear, never wrap, and SHALL be sized $clog2 of its limit plus 1.
REQ-025 The switch path SHALL operate independently of the sequencer state, so sw_o is valid before RUN.

Reset
REQ-026 On arst_n_i=0, all flops SHALL clear asynchronously: sequencer to ASSERT, rst_o=1, ready_o=0, irq_btn_o=0, sw_o=0, debounced button=0, all counters=0.
REQ-027 Assertion of arst_n_i mid-operation (HOLD, mid-debounce, during an irq pulse) SHALL abort that operation immediately, with no pulse emitted after release.
REQ-028 After arst_n_i releases with lock already high, rst_o SHALL fall no earlier than SYNC_STAGES+RST_HOLD_CYCLES cycles later.

Structure
REQ-029 Package board_io_pkg SHALL hold the sequencer state enum (ASSERT, HOLD, RUN) and the default constants for SYNC_STAGES, RST_HOLD_CYCLES and DEBOUNCE_CYCLES.
REQ-030 Sub-module io_debounce, parameterized by WIDTH, SYNC_STAGES and DEBOUNCE_CYCLES, SHALL implement synchronizer plus debouncer, instantiated twice (WIDTH=1 for the button, WIDTH=SW_WIDTH for the switches).
REQ-031 The sequencer, edge detection and RUN gating SHALL stay in the top module.

Verification (SYNC_STAGES=2, RST_HOLD_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-032 Lock held high, arst_n_i released at cycle 0 -> rst_o falls at cycle 6, and ready_o rises in the same cycle.
REQ-033 pll_locked_i dropped for 1 cycle while in RUN -> rst_o=1 within 3 cycles, then 4 hold cycles after lock returns, then RUN.
REQ-034 btn_i toggling every 3 cycles for 40 cycles, then held at 1 -> exactly one irq_btn_o pulse, 8+3 cycles after the last edge.
REQ-035 sw_i changes 0x0000->0xA5A5, with bit 0 flipped back at cycle 5 -> sw_o stays 0x0000 until 8 stable cycles after the last change, then becomes 0xA5A4.
REQ-036 Button pressed and debounced while rst_o=1, then still held when RUN is entered -> no irq_btn_o pulse; a release and second press -> one pulse.
